seq_restoring_divider: RTL and testbench

//   Sequential restoring divider: inverse of the 4x4 Wallace multiplier datapath. Takes a 2*WIDTH-bit

---
 rtl/seq_restoring_divider.sv | 186 ++++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//
// Sequential restoring divider. Divides a 2*WIDTH-bit unsigned dividend by a
// WIDTH-bit unsigned divisor, producing one quotient bit per clock. The result
// is a WIDTH-bit quotient and remainder. When the true quotient does not fit in
// WIDTH bits (which includes divisor == 0) the result is flagged with ovf and
// forced to quotient = all ones, remainder = 0.
//
// Operation:  IDLE --accept--> CALC (WIDTH steps) --> DONE --handoff--> IDLE
//   in_ready  is high only in IDLE, out_valid only in DONE.
//   Without the bypass, every operation (overflowing or not) spends WIDTH
//   steps in CALC, so out_valid rises WIDTH edges after the accept edge.
//
// Build option:
//   DIV_OVF_BYPASS_EN  when defined, an overflow detected at accept goes
//                      straight from IDLE to DONE on the accept edge, skipping
//                      CALC. Undefined by default.
//
// Parameters:
//   WIDTH      divisor / quotient / remainder width (>= 2); dividend is 2*WIDTH
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any operation in flight
//   in_valid   operands valid
//   in_ready   divider can accept operands (IDLE)
//   dividend   unsigned dividend, 2*WIDTH bits
//   divisor    unsigned divisor, WIDTH bits
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   quotient   unsigned quotient, WIDTH bits
//   remainder  unsigned remainder, WIDTH bits
//   ovf        quotient overflow (includes divide by zero)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               ovf
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_acc;   // partial remainder between steps (always < divisor)
    logic [WIDTH-1:0] dvd_lo;    // dividend bits still to be shifted in, MSB first
    logic [WIDTH-1:0] dvs;       // registered divisor
    logic [WIDTH-1:0] q_acc;     // quotient bits collected so far
    logic             ovf_acc;   // overflow decided at accept

    logic             accept;
    logic             handoff;
    logic             ovf_det;
    logic             last_step;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] q_step;

    assign accept    = in_valid && in_ready;
    assign handoff   = out_valid && out_ready;
    // Quotient fits in WIDTH bits only if the upper dividend half is below the
    // divisor; a zero divisor therefore always overflows.
    assign ovf_det   = (dividend[2*WIDTH-1:WIDTH] >= divisor);
    assign last_step = (state == CALC) && (cnt == '0);

    // One restoring step: shift in the next dividend bit, subtract if possible.
    // When ge holds the true difference is below the divisor, so computing it
    // modulo 2^WIDTH loses nothing.
    assign shifted  = {rem_acc, dvd_lo[WIDTH-1]};
    assign ge       = (shifted >= {1'b0, dvs});
    assign rem_step = ge ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
    assign q_step   = {q_acc[WIDTH-2:0], ge};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef DIV_OVF_BYPASS_EN
                    state_nxt = ovf_det ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(WIDTH - 1);
        end else if ((state == CALC) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Datapath: loaded on accept, stepped in CALC. Not reset: every field is
    // written at accept before it is ever used.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_acc <= dividend[2*WIDTH-1:WIDTH];
            dvd_lo  <= dividend[WIDTH-1:0];
            dvs     <= divisor;
            q_acc   <= '0;
            ovf_acc <= ovf_det;
        end else if (state == CALC) begin
            rem_acc <= rem_step;
            dvd_lo  <= dvd_lo << 1;
            q_acc   <= q_step;
        end
    end

    // Result registers: written once per operation on entry to DONE and held
    // until the next result, so they stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
        end else if (last_step) begin
            // Overflowed operations ran through CALC only for fixed latency;
            // their datapath contents are meaningless and are overridden.
            quotient  <= ovf_acc ? {WIDTH{1'b1}} : q_step;
            remainder <= ovf_acc ? '0 : rem_step;
            ovf       <= ovf_acc;
        end
`ifdef DIV_OVF_BYPASS_EN
        else if (accept && ovf_det) begin
            quotient  <= {WIDTH{1'b1}};
            remainder <= '0;
            ovf       <= 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_restoring_divider
//
// Self-checking bench for seq_restoring_divider (WIDTH = 4). A transaction
// model computes each result with plain integer division and tracks when the
// result must appear; a negedge compare process checks the handshake every
// cycle and the result fields whenever a result is due. Directed operations
// pin the model with hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_restoring_divider;

    localparam int W    = 4;
    localparam int MAXQ = (1 << W) - 1;
`ifdef DIV_OVF_BYPASS_EN
    localparam bit BYPASS  = 1'b1;
    localparam int LAT_OVF = 0;   // result already valid right after the accept edge
`else
    localparam bit BYPASS  = 1'b0;
    localparam int LAT_OVF = W;
`endif

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           ovf;

    int n_tests = 0;
    int n_fail  = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference division: {ovf, quotient, remainder}
    function automatic logic [2*W:0] ref_div(input int dd, input int ds);
        int q;
        int r;
        if (ds == 0) return {1'b1, W'(MAXQ), W'(0)};
        q = dd / ds;
        r = dd % ds;
        if (q > MAXQ) return {1'b1, W'(MAXQ), W'(0)};
        return {1'b0, W'(q), W'(r)};
    endfunction

    // Transaction model: 0 = waiting for operands, 1 = computing, 2 = result due
    int           m_st;
    int           m_cd;
    logic [W-1:0] m_q;
    logic [W-1:0] m_r;
    logic         m_o;

    always @(posedge clk or negedge rst_n) begin
        logic [2*W:0] res;
        if (!rst_n) begin
            m_st <= 0;
            m_cd <= 0;
        end else begin
            case (m_st)
                0: if (in_valid) begin
                    res = ref_div(int'(dividend), int'(divisor));
                    {m_o, m_q, m_r} <= res;
                    if (res[2*W] && BYPASS) begin
                        m_st <= 2;
                    end else begin
                        m_st <= 1;
                        m_cd <= W;
                    end
                end
                1: begin
                    m_cd <= m_cd - 1;
                    if (m_cd == 1) m_st <= 2;
                end
                default: if (out_ready) m_st <= 0;
            endcase
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(m_st == 0));
            chk("out_valid", 32'(out_valid), 32'(m_st == 2));
            if (m_st == 2) begin
                chk("quotient", 32'(quotient), 32'(m_q));
                chk("remainder", 32'(remainder), 32'(m_r));
                chk("ovf", 32'(ovf), 32'(m_o));
            end
        end
    end

    // Directed operation with hand-computed expectations. out_ready stays high.
    // Latency is counted in clock edges after the accept edge.
    task automatic do_op(input int dd, input int ds, input int eq, input int er,
                         input int eo, input int elat, input string nm);
        int t;
        int lat;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = dd[2*W-1:0];
        divisor   = ds[W-1:0];
        @(posedge clk); #1;
        in_valid  = 1'b0;
        dividend  = 8'($urandom);      // operand changes after accept must not matter
        divisor   = 4'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_q"}, 32'(quotient), 32'(eq));
        chk({nm, "_r"}, 32'(remainder), 32'(er));
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk); #1;
        chk({nm, "_handoff_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_handoff_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed cases
        do_op(143, 11, 13, 0, 0, W, "d143_11");
        do_op(100, 7, 14, 2, 0, W, "d100_7");
        do_op(200, 3, 15, 0, 1, LAT_OVF, "d200_3");
        do_op(5, 0, 15, 0, 1, LAT_OVF, "d5_0");
        do_op(0, 1, 0, 0, 0, W, "d0_1");
        do_op(239, 15, 15, 14, 0, W, "d239_15");
        do_op(240, 15, 15, 0, 1, LAT_OVF, "d240_15");

        // Backpressure: result held stable, no new operands taken
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = 8'd100;
        divisor   = 4'd7;
        @(posedge clk); #1;
        dividend  = 8'd50;            // still offered while busy, must be ignored
        divisor   = 4'd5;
        begin
            int t;
            t = 0;
            while (!out_valid && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            chk("bp_latency", 32'(t), 32'(W));
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_q", 32'(quotient), 32'd14);
            chk("bp_r", 32'(remainder), 32'd2);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a calculation
        in_valid = 1'b1;
        dividend = 8'd100;
        divisor  = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_q", 32'(quotient), 32'd0);
        chk("midrst_r", 32'(remainder), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        do_op(143, 11, 13, 0, 0, W, "post_rst");

        // Exhaustive exact products
        for (int x = 1; x <= MAXQ; x++) begin
            for (int y = 1; y <= MAXQ; y++) begin
                do_op(x * y, y, x, 0, 0, W, "exh");
            end
        end

        // Randomized traffic with random backpressure, checked by the model
        for (int i = 0; i < 1500; i++) begin
            in_valid  = 1'($urandom);
            divisor   = 4'($urandom);
            if (($urandom % 2) == 0 && divisor != 0)
                dividend = 8'(int'(divisor) * $urandom_range(0, MAXQ) + $urandom_range(0, int'(divisor) - 1));
            else
                dividend = 8'($urandom);
            out_ready = (($urandom % 4) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("drain_idle", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
